// File: rtl/mux_2to1_pkg.sv
// Shared constants for the mux_2to1 leaf selector and its skid buffer.
package mux_pkg;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  localparam int unsigned MUX_WIDTH_DEFAULT = 1;

endpackage

// File: rtl/mux_2to1_if.sv
// Bus bundle for mux_2to1: select inputs, combinational output and the
// valid/ready registered output path.
interface mux_2to1_if
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y_q;
  logic             y_valid;
  logic             y_ready;

  modport master (
    output in0, in1, sel, in_valid, y_ready,
    input  y, in_ready, y_q, y_valid
  );

  modport slave (
    input  in0, in1, sel, in_valid, y_ready,
    output y, in_ready, y_q, y_valid
  );

endinterface

// File: rtl/mux_2to1_skid_buf.sv
// Two-entry valid/ready skid buffer (main + skid) with a registered
// upstream ready that never depends combinationally on i_ready.
module mux_skid_buf
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_main_data;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             r_in_ready;

  logic [WIDTH-1:0] w_main_data_nxt;
  logic             w_main_valid_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;
  logic             w_skid_valid_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_valid && r_in_ready;
  assign w_pop   = r_main_valid && i_ready;

  assign o_ready = r_in_ready;
  assign o_data  = r_main_data;
  assign o_valid = r_main_valid;

  // Next-state for both entries; a push never coincides with a full skid
  // because r_in_ready is low whenever the skid entry is occupied.
  always_comb begin
    w_main_data_nxt  = r_main_data;
    w_main_valid_nxt = r_main_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_valid_nxt = r_skid_valid;
    if (w_pop || !r_main_valid) begin
      if (r_skid_valid) begin
        w_main_data_nxt  = r_skid_data;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_push) begin
        w_main_data_nxt  = i_data;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_push) begin
      w_skid_data_nxt  = i_data;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Entry registers; ready is held low during reset and tracks skid-empty after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main_data  <= w_main_data_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

endmodule

// File: rtl/mux_2to1.sv
// 2:1 data selector: combinational output y plus a registered,
// flow-controlled copy of the same selection through a skid buffer.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_2to1_if.slave   bus
);

  logic [WIDTH-1:0] w_sel_data;

  // Single selection feeds both the combinational output and the buffer input.
  assign w_sel_data = (bus.sel == SEL_IN0) ? bus.in0 : bus.in1;
  assign bus.y      = w_sel_data;

  mux_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (w_sel_data),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .o_data  (bus.y_q),
    .o_valid (bus.y_valid),
    .i_ready (bus.y_ready)
  );

endmodule

// File: tb/tb_mux_2to1.sv
// Directed-vector bench for mux_2to1: 4:1 combinational tree, WIDTH=8
// selection, reset, streaming, backpressure and mid-stream reset.
module tb_mux_2to1;

  logic clk;
  logic rst_n;
  int unsigned n_pass;
  int unsigned n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 device with the registered path
  mux_2to1_if #(.WIDTH(8)) u_if8 ();
  mux_2to1 #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(u_if8.slave));

  // 4:1 combinational tree from three WIDTH=1 leaves
  logic [3:0] r_i;
  logic [1:0] r_sel;
  mux_2to1_if #(.WIDTH(1)) u_ifa ();
  mux_2to1_if #(.WIDTH(1)) u_ifb ();
  mux_2to1_if #(.WIDTH(1)) u_ifc ();

  assign u_ifa.in0 = r_i[0];
  assign u_ifa.in1 = r_i[1];
  assign u_ifa.sel = r_sel[0];
  assign u_ifb.in0 = r_i[2];
  assign u_ifb.in1 = r_i[3];
  assign u_ifb.sel = r_sel[0];
  assign u_ifc.in0 = u_ifa.y;
  assign u_ifc.in1 = u_ifb.y;
  assign u_ifc.sel = r_sel[1];
  assign u_ifa.in_valid = 1'b0;
  assign u_ifb.in_valid = 1'b0;
  assign u_ifc.in_valid = 1'b0;
  assign u_ifa.y_ready  = 1'b0;
  assign u_ifb.y_ready  = 1'b0;
  assign u_ifc.y_ready  = 1'b0;

  mux_2to1 #(.WIDTH(1)) u_l1a (.clk(clk), .rst_n(rst_n), .bus(u_ifa.slave));
  mux_2to1 #(.WIDTH(1)) u_l1b (.clk(clk), .rst_n(rst_n), .bus(u_ifb.slave));
  mux_2to1 #(.WIDTH(1)) u_l2  (.clk(clk), .rst_n(rst_n), .bus(u_ifc.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_tree();
    logic exp_y [4];
    exp_y[0] = 1'b0; exp_y[1] = 1'b1; exp_y[2] = 1'b0; exp_y[3] = 1'b1;
    r_i = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      r_sel = 2'(s);
      #10;
      n_total++;
      if (u_ifc.y !== exp_y[s])
        $display("FAIL tree sel=%0d: y=%b expected %b", s, u_ifc.y, exp_y[s]);
      else n_pass++;
    end
  endtask

  task automatic test_comb_w8();
    u_if8.in0 = 8'h3C;
    u_if8.in1 = 8'hA5;
    u_if8.sel = 1'b0;
    #1;
    n_total++;
    if (u_if8.y !== 8'h3C) $display("FAIL comb_sel0: y=%h expected 3c", u_if8.y);
    else n_pass++;
    u_if8.sel = 1'b1;
    #1;
    n_total++;
    if (u_if8.y !== 8'hA5) $display("FAIL comb_sel1: y=%h expected a5", u_if8.y);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if8.in_valid = 1'b1;
    u_if8.y_ready  = 1'b0;
    u_if8.in0 = 8'h5A;
    u_if8.sel = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++;
      if (u_if8.y_valid !== 1'b0) $display("FAIL reset_y_valid c%0d: got %b expected 0", c, u_if8.y_valid);
      else n_pass++;
      n_total++;
      if (u_if8.y_q !== 8'h00) $display("FAIL reset_y_q c%0d: got %h expected 00", c, u_if8.y_q);
      else n_pass++;
      n_total++;
      if (u_if8.in_ready !== 1'b0) $display("FAIL reset_in_ready c%0d: got %b expected 0", c, u_if8.in_ready);
      else n_pass++;
    end
    rst_n = 1'b1;
    u_if8.in_valid = 1'b0;
    tick();
    n_total++;
    if (u_if8.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", u_if8.in_ready);
    else n_pass++;
    n_total++;
    if (u_if8.y_valid !== 1'b0) $display("FAIL release_y_valid: got %b expected 0", u_if8.y_valid);
    else n_pass++;
  endtask

  task automatic test_streaming();
    logic [7:0] v_in0 [4];
    logic [7:0] v_in1 [4];
    logic [7:0] v_exp [4];
    v_in0[0] = 8'h11; v_in1[0] = 8'h22; v_exp[0] = 8'h11;
    v_in0[1] = 8'h33; v_in1[1] = 8'h44; v_exp[1] = 8'h44;
    v_in0[2] = 8'h55; v_in1[2] = 8'h66; v_exp[2] = 8'h55;
    v_in0[3] = 8'h77; v_in1[3] = 8'h88; v_exp[3] = 8'h88;
    u_if8.y_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      u_if8.in0 = v_in0[k];
      u_if8.in1 = v_in1[k];
      u_if8.sel = k[0];
      u_if8.in_valid = 1'b1;
      tick();
      n_total++;
      if (u_if8.y_valid !== 1'b1 || u_if8.y_q !== v_exp[k])
        $display("FAIL stream_%0d: y_valid=%b y_q=%h expected 1/%h", k, u_if8.y_valid, u_if8.y_q, v_exp[k]);
      else n_pass++;
      n_total++;
      if (u_if8.in_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", k, u_if8.in_ready);
      else n_pass++;
    end
    u_if8.in_valid = 1'b0;
    tick();
    n_total++;
    if (u_if8.y_valid !== 1'b0) $display("FAIL stream_drain: y_valid=%b expected 0", u_if8.y_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    u_if8.y_ready = 1'b0;
    u_if8.in0 = 8'hA1; u_if8.in1 = 8'h0F; u_if8.sel = 1'b0; u_if8.in_valid = 1'b1;
    tick();
    n_total++;
    if (u_if8.y_q !== 8'hA1 || u_if8.y_valid !== 1'b1 || u_if8.in_ready !== 1'b1)
      $display("FAIL bp_first: y_q=%h v=%b rdy=%b expected a1/1/1", u_if8.y_q, u_if8.y_valid, u_if8.in_ready);
    else n_pass++;
    u_if8.in0 = 8'h0E; u_if8.in1 = 8'hB2; u_if8.sel = 1'b1;
    tick();
    n_total++;
    if (u_if8.y_q !== 8'hA1 || u_if8.in_ready !== 1'b0)
      $display("FAIL bp_second: y_q=%h rdy=%b expected a1/0", u_if8.y_q, u_if8.in_ready);
    else n_pass++;
    u_if8.in0 = 8'hC3; u_if8.in1 = 8'h0D; u_if8.sel = 1'b0;
    tick();
    n_total++;
    if (u_if8.y_q !== 8'hA1 || u_if8.in_ready !== 1'b0)
      $display("FAIL bp_third_stall: y_q=%h rdy=%b expected a1/0", u_if8.y_q, u_if8.in_ready);
    else n_pass++;
    u_if8.y_ready = 1'b1;
    tick();
    n_total++;
    if (u_if8.y_q !== 8'hB2 || u_if8.y_valid !== 1'b1 || u_if8.in_ready !== 1'b1)
      $display("FAIL bp_release_b: y_q=%h v=%b rdy=%b expected b2/1/1", u_if8.y_q, u_if8.y_valid, u_if8.in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (u_if8.y_q !== 8'hC3 || u_if8.y_valid !== 1'b1)
      $display("FAIL bp_release_c: y_q=%h v=%b expected c3/1", u_if8.y_q, u_if8.y_valid);
    else n_pass++;
    u_if8.in_valid = 1'b0;
    tick();
    n_total++;
    if (u_if8.y_valid !== 1'b0) $display("FAIL bp_drain: y_valid=%b expected 0", u_if8.y_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    u_if8.y_ready = 1'b0;
    u_if8.in0 = 8'hD4; u_if8.sel = 1'b0; u_if8.in_valid = 1'b1;
    tick();
    u_if8.in0 = 8'hE5;
    tick();
    n_total++;
    if (u_if8.in_ready !== 1'b0 || u_if8.y_valid !== 1'b1 || u_if8.y_q !== 8'hD4)
      $display("FAIL mid_full: rdy=%b v=%b y_q=%h expected 0/1/d4", u_if8.in_ready, u_if8.y_valid, u_if8.y_q);
    else n_pass++;
    rst_n = 1'b0;
    u_if8.in_valid = 1'b0;
    tick();
    n_total++;
    if (u_if8.y_valid !== 1'b0 || u_if8.y_q !== 8'h00 || u_if8.in_ready !== 1'b0)
      $display("FAIL mid_reset: v=%b y_q=%h rdy=%b expected 0/00/0", u_if8.y_valid, u_if8.y_q, u_if8.in_ready);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++;
    if (u_if8.in_ready !== 1'b1 || u_if8.y_valid !== 1'b0)
      $display("FAIL mid_release: rdy=%b v=%b expected 1/0", u_if8.in_ready, u_if8.y_valid);
    else n_pass++;
    u_if8.y_ready = 1'b1;
    u_if8.in0 = 8'h3F; u_if8.in1 = 8'hF6; u_if8.sel = 1'b1; u_if8.in_valid = 1'b1;
    tick();
    n_total++;
    if (u_if8.y_q !== 8'hF6 || u_if8.y_valid !== 1'b1)
      $display("FAIL mid_fresh: y_q=%h v=%b expected f6/1", u_if8.y_q, u_if8.y_valid);
    else n_pass++;
    u_if8.in_valid = 1'b0;
    tick();
    n_total++;
    if (u_if8.y_valid !== 1'b0)
      $display("FAIL mid_empty: y_valid=%b y_q=%h expected 0", u_if8.y_valid, u_if8.y_q);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    r_i     = '0;
    r_sel   = '0;
    u_if8.in0      = '0;
    u_if8.in1      = '0;
    u_if8.sel      = 1'b0;
    u_if8.in_valid = 1'b0;
    u_if8.y_ready  = 1'b0;
    #2;
    test_comb_tree();
    test_comb_w8();
    test_reset();
    test_streaming();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
